// File: rtl/simon_controller.sv
// Simon sequencing FSM: game state, stored-pattern count and playback/repeat index.
// Updates land on the qualifying clk edge; mem_we/mem_addr are decoded from state, no backpressure.
module simon_controller #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              level,
  input  logic              pattern_ok,
  input  logic              match,
  output logic              level_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mode_leds,
  output logic              win,
  output logic              lose
);

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        LED_INPUT    = 3'b001;
  localparam logic [2:0]        LED_PLAYBACK = 3'b010;
  localparam logic [2:0]        LED_REPEAT   = 3'b100;
  localparam logic [2:0]        LED_DONE     = 3'b111;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count, count_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              first, first_nxt;
  logic              win_nxt, lose_nxt, level_q_nxt;
  logic [2:0]        mode_nxt;
  logic              last;
  logic              full;

  // Index compare is done at count width so count==DEPTH still finds its last slot.
  assign last = ({1'b0, idx} == (count - CNT_ONE));
  assign full = (count == DEPTH_C);

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    idx_nxt     = idx;
    first_nxt   = first;
    win_nxt     = win;
    lose_nxt    = lose;
    level_q_nxt = first ? level : level_q;
    case (state)
      S_INPUT: begin
        if (pattern_ok) begin
          count_nxt = count + CNT_ONE;
          first_nxt = 1'b0;
          idx_nxt   = '0;
          state_nxt = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        if (last) begin
          idx_nxt   = '0;
          state_nxt = S_REPEAT;
        end else begin
          idx_nxt = idx + IDX_ONE;
        end
      end
      S_REPEAT: begin
        if (!match) begin
          lose_nxt  = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_DONE;
        end else if (!last) begin
          idx_nxt = idx + IDX_ONE;
        end else if (full) begin
          win_nxt   = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_INPUT;
        end
      end
      S_DONE: begin
        idx_nxt = last ? '0 : idx + IDX_ONE;
      end
      default: begin
        state_nxt = S_INPUT;
      end
    endcase

    case (state_nxt)
      S_INPUT:    mode_nxt = LED_INPUT;
      S_PLAYBACK: mode_nxt = LED_PLAYBACK;
      S_REPEAT:   mode_nxt = LED_REPEAT;
      default:    mode_nxt = LED_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INPUT;
      count     <= '0;
      idx       <= '0;
      first     <= 1'b1;
      level_q   <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      mode_leds <= LED_INPUT;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      idx       <= idx_nxt;
      first     <= first_nxt;
      level_q   <= level_q_nxt;
      win       <= win_nxt;
      lose      <= lose_nxt;
      mode_leds <= mode_nxt;
    end
  end

  assign mem_we   = (state == S_INPUT) & pattern_ok;
  assign mem_addr = (state == S_INPUT) ? count[ADDR_W-1:0] : idx;

endmodule

// File: tb/tb_simon_controller.sv
// Directed bench for simon_controller: 64-entry instance for play/lose/reset, 4-entry instance for fill/win.
module tb_simon_controller;

  logic       clk;
  logic       rst_n, level, pattern_ok, match;
  logic       level_q, mem_we, win, lose;
  logic [5:0] mem_addr;
  logic [2:0] mode_leds;

  logic       rst2_n, level2, ok2, match2;
  logic       level_q2, we2, win2, lose2;
  logic [1:0] addr2;
  logic [2:0] mode2;

  int tests = 0;
  int fails = 0;

  simon_controller #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .pattern_ok(pattern_ok), .match(match),
    .level_q(level_q), .mem_addr(mem_addr), .mem_we(mem_we), .mode_leds(mode_leds),
    .win(win), .lose(lose)
  );

  simon_controller #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .level(level2), .pattern_ok(ok2), .match(match2),
    .level_q(level_q2), .mem_addr(addr2), .mem_we(we2), .mode_leds(mode2),
    .win(win2), .lose(lose2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; level = 1'b0; pattern_ok = 1'b0; match = 1'b0;
    rst2_n = 1'b0; level2 = 1'b0; ok2 = 1'b0; match2 = 1'b0;
    #12;
    check("rst_mode", 32'(mode_leds), 32'h1);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_win", 32'(win), 32'h0);
    check("rst_lose", 32'(lose), 32'h0);
    check("rst_level_q", 32'(level_q), 32'h0);

    // Illegal patterns are ignored; level follows while nothing is committed.
    step();
    rst_n = 1'b1; level = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_mode", 32'(mode_leds), 32'h1);
      check("t3_we", 32'(mem_we), 32'h0);
      check("t3_addr", 32'(mem_addr), 32'h0);
    end
    check("t2_level_follow", 32'(level_q), 32'h1);

    // Three rounds with correct repeats.
    for (int r = 1; r <= 3; r++) begin
      check("t4_in_mode", 32'(mode_leds), 32'h1);
      check("t4_in_addr", 32'(mem_addr), 32'(r - 1));
      pattern_ok = 1'b1;
      #1;
      check("t4_commit_we", 32'(mem_we), 32'h1);
      step();
      if (r == 1) level = 1'b0;
      for (int i = 0; i < r; i++) begin
        check("t4_pb_mode", 32'(mode_leds), 32'h2);
        check("t4_pb_addr", 32'(mem_addr), 32'(i));
        check("t4_pb_we", 32'(mem_we), 32'h0);
        step();
      end
      pattern_ok = 1'b0;
      match = 1'b1;
      for (int i = 0; i < r; i++) begin
        check("t4_rep_mode", 32'(mode_leds), 32'h4);
        check("t4_rep_addr", 32'(mem_addr), 32'(i));
        step();
      end
      match = 1'b0;
      check("t2_level_frozen", 32'(level_q), 32'h1);
    end
    check("t4_back_mode", 32'(mode_leds), 32'h1);
    check("t4_back_addr", 32'(mem_addr), 32'h3);

    // Round 4: asynchronous reset mid-REPEAT, checked before any clock edge.
    pattern_ok = 1'b1;
    step();
    pattern_ok = 1'b0;
    for (int i = 0; i < 4; i++) step();
    match = 1'b1;
    step();
    check("t1_pre_mode", 32'(mode_leds), 32'h4);
    check("t1_pre_addr", 32'(mem_addr), 32'h1);
    match = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_mode", 32'(mode_leds), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0);
    check("t1_we", 32'(mem_we), 32'h0);
    check("t1_win", 32'(win), 32'h0);
    check("t1_lose", 32'(lose), 32'h0);
    step();
    rst_n = 1'b1; level = 1'b0;
    step();
    check("t2_level_fresh", 32'(level_q), 32'h0);

    // Lose in round 2 at idx 1.
    pattern_ok = 1'b1;
    step();
    pattern_ok = 1'b0;
    step();
    match = 1'b1;
    step();
    check("t5_r1_addr", 32'(mem_addr), 32'h1);
    pattern_ok = 1'b1;
    step();
    pattern_ok = 1'b0;
    step();
    step();
    step();
    check("t5_rep_addr", 32'(mem_addr), 32'h1);
    match = 1'b0;
    step();
    check("t5_lose", 32'(lose), 32'h1);
    check("t5_win", 32'(win), 32'h0);
    check("t5_mode", 32'(mode_leds), 32'h7);
    check("t5_addr0", 32'(mem_addr), 32'h0);
    pattern_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t5_cycle_addr", 32'(mem_addr), 32'(k % 2));
      check("t5_cycle_we", 32'(mem_we), 32'h0);
      check("t5_cycle_mode", 32'(mode_leds), 32'h7);
      check("t5_cycle_lose", 32'(lose), 32'h1);
    end
    pattern_ok = 1'b0;

    // Fill a 4-entry memory and win.
    rst2_n = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      check("t6_in_mode", 32'(mode2), 32'h1);
      check("t6_in_addr", 32'(addr2), 32'(r - 1));
      ok2 = 1'b1;
      #1;
      check("t6_commit_we", 32'(we2), 32'h1);
      step();
      ok2 = 1'b0;
      for (int i = 0; i < r; i++) begin
        check("t6_pb_addr", 32'(addr2), 32'(i));
        step();
      end
      match2 = 1'b1;
      for (int i = 0; i < r; i++) begin
        check("t6_rep_mode", 32'(mode2), 32'h4);
        check("t6_rep_addr", 32'(addr2), 32'(i));
        step();
      end
      match2 = 1'b0;
    end
    check("t6_win", 32'(win2), 32'h1);
    check("t6_lose", 32'(lose2), 32'h0);
    check("t6_mode", 32'(mode2), 32'h7);
    check("t6_addr0", 32'(addr2), 32'h0);
    check("t6_level_q", 32'(level_q2), 32'h0);
    ok2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t6_cycle_addr", 32'(addr2), 32'(k % 4));
      check("t6_cycle_we", 32'(we2), 32'h0);
      check("t6_cycle_mode", 32'(mode2), 32'h7);
      check("t6_cycle_win", 32'(win2), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
